// File: rtl/xg_reg_if.sv
// rtl/xg_reg_if.sv - CPU register interface gathering pattern/attribute bursts for the XG memory manager
module xg_reg_if (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cpu_sel,
    input  logic        cpu_wren,
    input  logic [2:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        p_full,
    output logic        a_full,
    input  logic        p_pop,
    input  logic        a_pop,
    output logic [15:0] p_data,
    output logic [15:0] a_data,
    output logic [11:0] par,
    output logic [12:0] aar,
    output logic [7:0]  ri_h_coarse
);

    typedef enum logic {P_FILL, P_DRAIN} p_state_t;
    typedef enum logic {A_FILL, A_DRAIN} a_state_t;

    p_state_t    p_state_q, p_state_d;
    a_state_t    a_state_q, a_state_d;
    logic [4:0]  pwc_q, pwc_d;
    logic [3:0]  prp_q, prp_d;
    logic [2:0]  awc_q, awc_d;
    logic [1:0]  arp_q, arp_d;
    logic [11:0] par_q, par_d;
    logic [12:0] aar_q, aar_d;
    logic [7:0]  hc_q, hc_d;
    logic        p_ovf_q, p_ovf_d;
    logic        a_ovf_q, a_ovf_d;
    logic [15:0] rdata_q, rdata_d;
    logic        p_buf_we, a_buf_we;
    logic        p_ovf_set, a_ovf_set;

    logic [15:0] p_buf_q [16];
    logic [15:0] a_buf_q [4];

    logic wr, rd;
    logic wr_par, wr_pdat, wr_aar, wr_adat, wr_hc, wr_stat;

    assign wr      = cpu_sel & cpu_wren;
    assign rd      = cpu_sel & ~cpu_wren;
    assign wr_par  = wr && (cpu_addr == 3'd0);
    assign wr_pdat = wr && (cpu_addr == 3'd1);
    assign wr_aar  = wr && (cpu_addr == 3'd2);
    assign wr_adat = wr && (cpu_addr == 3'd3);
    assign wr_hc   = wr && (cpu_addr == 3'd4);
    assign wr_stat = wr && (cpu_addr == 3'd5);

    // State at the start of the cycle decides: a write alongside the final pop is still an overflow.
    always_comb begin
        p_state_d = p_state_q;
        pwc_d     = pwc_q;
        prp_d     = prp_q;
        par_d     = par_q;
        p_buf_we  = 1'b0;
        p_ovf_set = 1'b0;
        case (p_state_q)
            P_FILL: begin
                if (wr_pdat) begin
                    p_buf_we = 1'b1;
                    pwc_d    = pwc_q + 5'd1;
                    if (pwc_q == 5'd15) begin
                        p_state_d = P_DRAIN;
                        prp_d     = 4'd0;
                    end
                end else if (wr_par) begin
                    par_d = cpu_wdata[11:0];
                    pwc_d = 5'd0;
                end
            end
            P_DRAIN: begin
                p_ovf_set = wr_pdat | wr_par;
                if (p_pop) begin
                    prp_d = prp_q + 4'd1;
                    if (prp_q == 4'd15) begin
                        p_state_d = P_FILL;
                        pwc_d     = 5'd0;
                        par_d     = par_q + 12'd1;
                    end
                end
            end
            default: p_state_d = P_FILL;
        endcase
    end

    always_comb begin
        a_state_d = a_state_q;
        awc_d     = awc_q;
        arp_d     = arp_q;
        aar_d     = aar_q;
        a_buf_we  = 1'b0;
        a_ovf_set = 1'b0;
        case (a_state_q)
            A_FILL: begin
                if (wr_adat) begin
                    a_buf_we = 1'b1;
                    awc_d    = awc_q + 3'd1;
                    if (awc_q == 3'd3) begin
                        a_state_d = A_DRAIN;
                        arp_d     = 2'd0;
                    end
                end else if (wr_aar) begin
                    aar_d = cpu_wdata[12:0];
                    awc_d = 3'd0;
                end
            end
            A_DRAIN: begin
                a_ovf_set = wr_adat | wr_aar;
                if (a_pop) begin
                    arp_d = arp_q + 2'd1;
                    if (arp_q == 2'd3) begin
                        a_state_d = A_FILL;
                        awc_d     = 3'd0;
                        aar_d     = aar_q + 13'd4;
                    end
                end
            end
            default: a_state_d = A_FILL;
        endcase
    end

    // A new overflow beats a same-cycle STATUS clear.
    always_comb begin
        p_ovf_d = p_ovf_set ? 1'b1 : (wr_stat ? 1'b0 : p_ovf_q);
        a_ovf_d = a_ovf_set ? 1'b1 : (wr_stat ? 1'b0 : a_ovf_q);
        hc_d    = wr_hc ? cpu_wdata[7:0] : hc_q;
        rdata_d = rdata_q;
        if (rd) begin
            case (cpu_addr)
                3'd0:    rdata_d = {4'd0, par_q};
                3'd2:    rdata_d = {3'd0, aar_q};
                3'd4:    rdata_d = {8'd0, hc_q};
                3'd5:    rdata_d = {12'd0, a_ovf_q, p_ovf_q, a_full, p_full};
                default: rdata_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            p_state_q <= P_FILL;
            a_state_q <= A_FILL;
            pwc_q     <= 5'd0;
            prp_q     <= 4'd0;
            awc_q     <= 3'd0;
            arp_q     <= 2'd0;
            par_q     <= 12'd0;
            aar_q     <= 13'd0;
            hc_q      <= 8'd0;
            p_ovf_q   <= 1'b0;
            a_ovf_q   <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            p_state_q <= p_state_d;
            a_state_q <= a_state_d;
            pwc_q     <= pwc_d;
            prp_q     <= prp_d;
            awc_q     <= awc_d;
            arp_q     <= arp_d;
            par_q     <= par_d;
            aar_q     <= aar_d;
            hc_q      <= hc_d;
            p_ovf_q   <= p_ovf_d;
            a_ovf_q   <= a_ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (p_buf_we) p_buf_q[pwc_q[3:0]] <= cpu_wdata;
        if (a_buf_we) a_buf_q[awc_q[1:0]] <= cpu_wdata;
    end

    assign p_full      = (p_state_q == P_DRAIN);
    assign a_full      = (a_state_q == A_DRAIN);
    assign p_data      = p_buf_q[prp_q];
    assign a_data      = a_buf_q[arp_q];
    assign par         = par_q;
    assign aar         = aar_q;
    assign ri_h_coarse = hc_q;
    assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_xg_reg_if.sv
// tb/tb_xg_reg_if.sv - self-checking bench for xg_reg_if
module tb_xg_reg_if;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_sel = 1'b0;
    logic        cpu_wren = 1'b0;
    logic [2:0]  cpu_addr = 3'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic [15:0] cpu_rdata;
    logic        p_full, a_full;
    logic        p_pop = 1'b0;
    logic        a_pop = 1'b0;
    logic [15:0] p_data, a_data;
    logic [11:0] par;
    logic [12:0] aar;
    logic [7:0]  ri_h_coarse;

    xg_reg_if dut (
        .clk_sys(clk_sys), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .p_full(p_full), .a_full(a_full), .p_pop(p_pop), .a_pop(a_pop),
        .p_data(p_data), .a_data(a_data), .par(par), .aar(aar),
        .ri_h_coarse(ri_h_coarse)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference model: bursts as word queues, registers as plain values.
    logic [15:0] mp_q[$];
    logic [15:0] ma_q[$];
    bit          mp_dr, ma_dr;
    logic [11:0] m_par;
    logic [12:0] m_aar;
    logic [7:0]  m_hc;
    bit          m_povf, m_aovf;
    logic [15:0] m_rdata;

    typedef struct {
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p_full"}, 16'(p_full), 16'(mp_dr));
        chk({tag, ".a_full"}, 16'(a_full), 16'(ma_dr));
        chk({tag, ".par"}, 16'(par), 16'(m_par));
        chk({tag, ".aar"}, 16'(aar), 16'(m_aar));
        chk({tag, ".hc"}, 16'(ri_h_coarse), 16'(m_hc));
        chk({tag, ".rdata"}, cpu_rdata, m_rdata);
        if (mp_dr) chk({tag, ".p_data"}, p_data, mp_q[0]);
        if (ma_dr) chk({tag, ".a_data"}, a_data, ma_q[0]);
    endtask

    task automatic cyc(input bit sel, input bit wr, input logic [2:0] addr,
                       input logic [15:0] wd, input bit pp, input bit ap);
        bit w;
        cpu_sel = sel; cpu_wren = wr; cpu_addr = addr; cpu_wdata = wd;
        p_pop = pp; a_pop = ap;
        w = sel && wr;
        if (sel && !wr) begin
            case (addr)
                3'd0:    m_rdata = 16'(m_par);
                3'd2:    m_rdata = 16'(m_aar);
                3'd4:    m_rdata = 16'(m_hc);
                3'd5:    m_rdata = {12'd0, m_aovf, m_povf, ma_dr, mp_dr};
                default: m_rdata = 16'd0;
            endcase
        end
        if (w && addr == 3'd5) begin m_povf = 0; m_aovf = 0; end
        if (w && addr == 3'd4) m_hc = wd[7:0];
        if (mp_dr) begin
            if (w && (addr == 3'd0 || addr == 3'd1)) m_povf = 1;
            if (pp) begin
                void'(mp_q.pop_front());
                if (mp_q.size() == 0) begin mp_dr = 0; m_par = m_par + 12'd1; end
            end
        end else if (w && addr == 3'd1) begin
            mp_q.push_back(wd);
            if (mp_q.size() == 16) mp_dr = 1;
        end else if (w && addr == 3'd0) begin
            mp_q.delete(); m_par = wd[11:0];
        end
        if (ma_dr) begin
            if (w && (addr == 3'd2 || addr == 3'd3)) m_aovf = 1;
            if (ap) begin
                void'(ma_q.pop_front());
                if (ma_q.size() == 0) begin ma_dr = 0; m_aar = m_aar + 13'd4; end
            end
        end else if (w && addr == 3'd3) begin
            ma_q.push_back(wd);
            if (ma_q.size() == 4) ma_dr = 1;
        end else if (w && addr == 3'd2) begin
            ma_q.delete(); m_aar = wd[12:0];
        end
        @(posedge clk_sys); #1;
        cpu_sel = 0; cpu_wren = 0; p_pop = 0; a_pop = 0;
        check_all("cyc");
    endtask

    task automatic wr_reg(input logic [2:0] addr, input logic [15:0] wd);
        cyc(1, 1, addr, wd, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk_sys); #1;
        rst = 0;
        mp_q.delete(); ma_q.delete();
        mp_dr = 0; ma_dr = 0; m_par = 0; m_aar = 0; m_hc = 0;
        m_povf = 0; m_aovf = 0; m_rdata = 0;
        check_all("reset");
    endtask

    initial begin
        vec_t tbl[9];
        tbl[0] = '{3'd0, 16'hFFFF, 3'd0, 16'h0FFF};
        tbl[1] = '{3'd2, 16'hFFFF, 3'd2, 16'h1FFF};
        tbl[2] = '{3'd4, 16'hFFFF, 3'd4, 16'h00FF};
        tbl[3] = '{3'd0, 16'h0ABC, 3'd0, 16'h0ABC};
        tbl[4] = '{3'd2, 16'h1234, 3'd2, 16'h1234};
        tbl[5] = '{3'd4, 16'h005A, 3'd4, 16'h005A};
        tbl[6] = '{3'd6, 16'hFFFF, 3'd6, 16'h0000};
        tbl[7] = '{3'd7, 16'h1234, 3'd7, 16'h0000};
        tbl[8] = '{3'd5, 16'hFFFF, 3'd5, 16'h0000};

        do_reset();
        chk("reset_p_full", 16'(p_full), 16'd0);
        chk("reset_rdata", cpu_rdata, 16'd0);

        for (int i = 0; i < 9; i++) begin
            wr_reg(tbl[i].waddr, tbl[i].wdata);
            cyc(1, 0, tbl[i].raddr, 16'd0, 0, 0);
            chk("tbl_rd", cpu_rdata, tbl[i].exp);
        end
        do_reset();

        // pattern burst
        wr_reg(3'd0, 16'h0123);
        for (int i = 0; i < 16; i++) begin
            wr_reg(3'd1, 16'h1000 + 16'(i));
            chk("fill_p_full", 16'(p_full), 16'(i == 15));
        end
        chk("burst_p_data0", p_data, 16'h1000);
        for (int i = 0; i < 16; i++) begin
            chk("drain_step", p_data, 16'h1000 + 16'(i));
            cyc(0, 0, 3'd0, 16'd0, 1, 0);
        end
        chk("burst_end_full", 16'(p_full), 16'd0);
        chk("burst_end_par", 16'(par), 16'h0124);

        // attribute wrap and pattern index wrap
        wr_reg(3'd2, 16'h1FFC);
        for (int i = 0; i < 4; i++) wr_reg(3'd3, 16'h2000 + 16'(i));
        chk("a_full", 16'(a_full), 16'd1);
        for (int i = 0; i < 4; i++) begin
            chk("a_step", a_data, 16'h2000 + 16'(i));
            cyc(0, 0, 3'd0, 16'd0, 0, 1);
        end
        chk("aar_wrap", 16'(aar), 16'h0000);
        chk("a_full_end", 16'(a_full), 16'd0);
        wr_reg(3'd0, 16'h0FFF);
        for (int i = 0; i < 16; i++) wr_reg(3'd1, 16'(i));
        for (int i = 0; i < 16; i++) cyc(0, 0, 3'd0, 16'd0, 1, 0);
        chk("par_wrap", 16'(par), 16'h0000);

        // overflow while full
        for (int i = 0; i < 16; i++) wr_reg(3'd1, 16'h3000 + 16'(i));
        wr_reg(3'd1, 16'hDEAD);
        wr_reg(3'd0, 16'h0555);
        chk("ovf_par", 16'(par), 16'h0000);
        chk("ovf_p_data", p_data, 16'h3000);
        cyc(1, 0, 3'd5, 16'd0, 0, 0);
        chk("ovf_status", cpu_rdata, 16'h0005);
        wr_reg(3'd5, 16'h0000);
        cyc(1, 0, 3'd5, 16'd0, 0, 0);
        chk("ovf_cleared", cpu_rdata, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain", p_data, 16'h3000 + 16'(i));
            cyc(0, 0, 3'd0, 16'd0, 1, 0);
        end

        // final pop with a write in the same cycle: write dropped
        for (int i = 0; i < 16; i++) wr_reg(3'd1, 16'h6000 + 16'(i));
        for (int i = 0; i < 15; i++) cyc(0, 0, 3'd0, 16'd0, 1, 0);
        cyc(1, 1, 3'd1, 16'hBEEF, 1, 0);
        chk("lastpop_full", 16'(p_full), 16'd0);
        cyc(1, 0, 3'd5, 16'd0, 0, 0);
        chk("lastpop_ovf", cpu_rdata, 16'h0004);
        wr_reg(3'd5, 16'h0000);

        // partial burst discarded by PAR write
        for (int i = 0; i < 5; i++) wr_reg(3'd1, 16'h4000 + 16'(i));
        wr_reg(3'd0, 16'h0040);
        for (int i = 0; i < 16; i++) wr_reg(3'd1, 16'h5000 + 16'(i));
        chk("discard_p_data", p_data, 16'h5000);
        chk("discard_par", 16'(par), 16'h0040);
        for (int i = 0; i < 16; i++) cyc(0, 0, 3'd0, 16'd0, 1, 0);

        // both paths full, alternate pops, then reset mid-drain
        wr_reg(3'd2, 16'h0100);
        for (int i = 0; i < 4; i++) wr_reg(3'd3, 16'h7000 + 16'(i));
        for (int i = 0; i < 16; i++) wr_reg(3'd1, 16'h8000 + 16'(i));
        chk("both_p_full", 16'(p_full), 16'd1);
        chk("both_a_full", 16'(a_full), 16'd1);
        wr_reg(3'd4, 16'h0033);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 3'd0, 16'd0, 1, 0);
            if (i < 4) cyc(0, 0, 3'd0, 16'd0, 0, 1);
        end
        chk("conc_p_data", p_data, 16'h8007);
        chk("conc_aar", 16'(aar), 16'h0104);
        do_reset();
        chk("rst_p_full", 16'(p_full), 16'd0);
        chk("rst_a_full", 16'(a_full), 16'd0);
        chk("rst_par", 16'(par), 16'd0);
        chk("rst_aar", 16'(aar), 16'd0);
        chk("rst_hc", 16'(ri_h_coarse), 16'd0);

        // read latency and hold
        cyc(1, 0, 3'd2, 16'd0, 0, 0);
        wr_reg(3'd4, 16'h00A5);
        chk("hold_before_read", cpu_rdata, 16'h0000);
        cyc(1, 0, 3'd4, 16'd0, 0, 0);
        chk("rd_latency", cpu_rdata, 16'h00A5);
        chk("hc_value", 16'(ri_h_coarse), 16'h00A5);
        cyc(0, 0, 3'd0, 16'd0, 0, 0);
        chk("rd_hold", cpu_rdata, 16'h00A5);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [2:0] a;
            r = $urandom_range(0, 99);
            if (r < 45)      a = 3'd1;
            else if (r < 72) a = 3'd3;
            else if (r < 76) a = 3'd0;
            else if (r < 80) a = 3'd2;
            else if (r < 88) a = 3'd4;
            else if (r < 96) a = 3'd5;
            else             a = 3'($urandom_range(6, 7));
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), a,
                16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xg_reg_if.md
# xg_reg_if

CPU-facing register interface for the XG tile graphics engine. It sits directly upstream of the XG memory manager. It gathers CPU writes of pattern data into 16-word tile bursts and attribute data into 4-word bursts, and presents each full burst to the manager through a full/pop handshake. It also holds the pattern and attribute address registers (`par`, `aar`) and the coarse horizontal scroll register (`ri_h_coarse`).

## Interface
- No parameters.
- `clk_sys`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high; clock `clk_sys`.
- `cpu_sel`  in  1  register access strobe, one access per cycle it is high.
- `cpu_wren`  in  1  1 = write, 0 = read (qualified by `cpu_sel`).
- `cpu_addr`  in  3  register select.
- `cpu_wdata`  in  16  write data.
- `cpu_rdata`  out  16  read data, registered.
- `p_full`  out  1  pattern burst (16 words) ready for the manager.
- `a_full`  out  1  attribute burst (4 words) ready for the manager.
- `p_pop`  in  1  consume the head pattern word.
- `a_pop`  in  1  consume the head attribute word.
- `p_data`  out  16  head pattern word (show-ahead).
- `a_data`  out  16  head attribute word (show-ahead).
- `par`  out  12  pattern index for the current burst.
- `aar`  out  13  attribute word address for the current burst.
- `ri_h_coarse`  out  8  coarse horizontal scroll.

## Operation
- Register map, selected by `cpu_addr`:
  - 0: PAR. Read/write, bits [11:0].
  - 1: pattern data port. Write only.
  - 2: AAR. Read/write, bits [12:0].
  - 3: attribute data port. Write only.
  - 4: H_COARSE. Read/write, bits [7:0].
  - 5: STATUS. Read returns {12'b0, a_ovf, p_ovf, a_full, p_full}. Any write clears `p_ovf` and `a_ovf`.
  - 6, 7: read 0, writes ignored.
- Pattern path: a 16×16 buffer with write count `pwc` (5 bits) and read pointer `prp` (4 bits). Two states, P_FILL and P_DRAIN.
  - P_FILL: a data-port write stores the word at `pwc[3:0]` and increments `pwc`. When `pwc` reaches 16, go to P_DRAIN and set `prp` = 0.
  - P_DRAIN: `p_full`=1 and `p_data` = buf[`prp`]. Each `p_pop` increments `prp`. The pop with `prp`=15 returns the block to P_FILL, sets `pwc`=0, and sets `par` ← `par`+1 (mod 4096).
  - P_DRAIN: data-port writes and PAR writes are dropped and set `p_ovf`.
  - P_FILL: a PAR write loads `par` and resets `pwc` to 0, discarding the partial burst.
  - `p_pop` while in P_FILL is ignored.
- Attribute path: identical structure with a 4-word buffer, count `awc` (3 bits), pointer `arp` (2 bits), states A_FILL and A_DRAIN, and sticky flag `a_ovf`.
  - The pop with `arp`=3 returns to A_FILL and sets `aar` ← `aar`+4 (mod 8192).
  - An AAR write in A_FILL loads `aar` and resets `awc`.
- H_COARSE: a plain register. It is never blocked.
- Simultaneous events:
  - A pop in the same cycle as a data-port write: the state at the start of the cycle decides. The final pop and a write in the same cycle means the write is dropped and `p_ovf` is set.
  - Reading STATUS in the same cycle as an overflow: the read returns the old flag value.
  - Writing STATUS in the same cycle as a new overflow: the set wins.
- Pattern and attribute paths are independent and may be full together.

## Timing
- Reset values: `cpu_rdata`=0, `p_full`=0, `a_full`=0, `par`=0, `aar`=0, `ri_h_coarse`=0. In addition `pwc`=0, `awc`=0, `prp`=0, `arp`=0, `p_ovf`=0, `a_ovf`=0, and both paths are in their FILL state.
- `p_data` and `a_data` are X-tolerant out of reset. The buffer contents themselves are not reset.
- Reset mid-drain aborts the burst. `p_full` and `a_full` are 0 in the cycle after `rst` is sampled.
- Reads: `cpu_rdata` is valid the cycle after `cpu_sel` with `cpu_wren`=0, and holds until the next read.
- Fill to full: `p_full` rises the cycle after the 16th data-port write is sampled. `a_full` behaves the same after the 4th write.
- Drain: `p_data` changes to the next word the cycle after each pop. The consumer may pop on consecutive cycles.
- End of burst: `p_full` falls, and `par` shows the incremented value, the cycle after the 16th pop. `a_full` and `aar` behave the same after the 4th pop.
- The next burst accepts writes from that cycle on.
- `par`, `aar`, and `ri_h_coarse` are registered. The manager samples `par`/`aar` during the burst, so they must be stable while FULL.

## Test plan
- Pattern burst: write PAR=0x123, then data words 0x1000..0x100F. Expect `p_full`=1 and `p_data`=0x1000. Pop on 16 consecutive cycles and expect `p_data` to step 0x1000→0x100F. Then `p_full`=0 and `par`=0x124.
- Attribute burst plus wrap: write AAR=0x1FFC and 4 words. Expect `a_full`. After 4 pops, expect `aar`=0x0000. Also write PAR=0xFFF, run one burst, and expect `par`=0x000.
- Overflow: while `p_full`=1, write the pattern data port and PAR. Buffer and `par` are unchanged and STATUS reads 0x0005. Write STATUS; it then reads 0x0001.
- Partial discard: write 5 pattern words, then PAR=0x040, then 16 words. `p_data` starts at the first of the 16 words and `par`=0x040.
- Concurrency and reset: fill both paths so `p_full`=`a_full`=1, and pop alternately; each path drains independently. Assert `rst` after 7 pattern pops; the next cycle `p_full`=`a_full`=0 and `par`=`aar`=`ri_h_coarse`=0.
- Read latency: write H_COARSE=0xA5, then read it. `cpu_rdata`=0x00A5 exactly one cycle after the read strobe, and `ri_h_coarse`=0xA5.
